data_memory: RTL and testbench

- Small multi-ported storage array: 8 entries x 8 bits, two independent asynchronous read ports and one synchronous write port.
- Serves as the datapath's register/data store. Operands are read combinationally and results are written back on each rising clock edge.
- Has no write-enable. A write is performed on every clock edge that is not under reset.

---
 rtl/data_memory.sv | 36 +++
 tb/tb_data_memory.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Eight-entry register/data store: two combinational read ports and one write port
// that writes on every rising clock edge outside reset. An asynchronous reset clears all entries.
module data_memory #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] ReadReg1,
   input  logic [ADDR_WIDTH-1:0] ReadReg2,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // No write enable: the entry at WriteReg is overwritten on every edge outside reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         mem[WriteReg] <= WriteData;
      end
   end

   // There is no write bypass, so a same-address read shows the old value until the edge.
   assign ReadData1 = mem[ReadReg1];
   assign ReadData2 = mem[ReadReg2];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, write/read-back, sequential fill,
// read-during-write, shared-address reads and asynchronous reset mid-operation.
module tb_data_memory;

   logic       clk;
   logic       rst;
   logic [2:0] ReadReg1;
   logic [2:0] ReadReg2;
   logic [2:0] WriteReg;
   logic [7:0] WriteData;
   logic [7:0] ReadData1;
   logic [7:0] ReadData2;

   int errors = 0;
   int checks = 0;

   data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   // Period 100, first rising edge at t=50.
   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < 8; a++) begin
         ReadReg1 = a[2:0];
         ReadReg2 = 3'(7 - a);
         #1;
         check($sformatf("%s_rd1_a%0d", tag, a), ReadData1, 8'h00);
         check($sformatf("%s_rd2_a%0d", tag, 7 - a), ReadData2, 8'h00);
      end
   endtask

   initial begin
      rst       = 1'b0;
      ReadReg1  = 3'd0;
      ReadReg2  = 3'd0;
      WriteReg  = 3'd0;
      WriteData = 'x;

      // Reset: X written to entry 0 at t=50, reset at t=75..175.
      #75 rst = 1'b1;
      #1;
      check_all_zero("in_reset");
      @(posedge clk);
      #25;
      rst       = 1'b0;
      WriteReg  = 3'd0;
      WriteData = 8'd10;
      check_all_zero("post_reset");

      // Single write / read-back after the t=250 edge.
      @(posedge clk);
      #1;
      ReadReg1 = 3'd0;
      #1;
      check("readback_e0", ReadData1, 8'd10);

      // Sequential fill with dual read.
      for (int k = 1; k <= 7; k++) begin
         WriteReg  = 3'(k);
         WriteData = 8'(k);
         ReadReg1  = 3'(k - 1);
         ReadReg2  = 3'(k);
         @(negedge clk);
         #1;
         check($sformatf("fill_pre_rd1_k%0d", k), ReadData1, (k == 1) ? 8'd10 : 8'(k - 1));
         check($sformatf("fill_pre_rd2_k%0d", k), ReadData2, 8'h00);
         @(posedge clk);
         #1;
         check($sformatf("fill_post_rd2_k%0d", k), ReadData2, 8'(k));
         check($sformatf("fill_post_rd1_k%0d", k), ReadData1, (k == 1) ? 8'd10 : 8'(k - 1));
      end

      // Read during write to the same address: old value before, new after.
      WriteReg  = 3'd3;
      WriteData = 8'h55;
      ReadReg1  = 3'd3;
      @(negedge clk);
      #1;
      check("rdw_pre", ReadData1, 8'd3);
      @(posedge clk);
      #1;
      check("rdw_post", ReadData1, 8'h55);

      // Both ports on the same address, then port 2 wraps to entry 0.
      WriteReg  = 3'd7;
      WriteData = 8'd7;
      ReadReg1  = 3'd7;
      ReadReg2  = 3'd7;
      @(negedge clk);
      #1;
      check("same_rd1", ReadData1, 8'd7);
      check("same_rd2", ReadData2, 8'd7);
      ReadReg2 = 3'd0;
      #1;
      check("wrap_rd2", ReadData2, 8'd10);
      ReadReg2 = 3'd3;
      #1;
      check("e3_after_rdw", ReadData2, 8'h55);

      // Asynchronous reset pulse between edges.
      @(posedge clk);
      #1;
      ReadReg1 = 3'd7;
      ReadReg2 = 3'd0;
      #1;
      check("pre_async_rd1", ReadData1, 8'd7);
      check("pre_async_rd2", ReadData2, 8'd10);
      #10 rst = 1'b1;
      #1;
      check("async_rd1", ReadData1, 8'h00);
      check("async_rd2", ReadData2, 8'h00);
      #10 rst = 1'b0;
      check_all_zero("after_async");

      // First edge after deassertion writes entry 7 again; the rest stay cleared.
      @(posedge clk);
      #1;
      ReadReg1 = 3'd7;
      ReadReg2 = 3'd6;
      #1;
      check("rewrite_e7", ReadData1, 8'd7);
      check("still_zero_e6", ReadData2, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
